clz_seq: RTL and testbench

- Multi-cycle leading-zero counter and normaliser for words wider than a single LZD tree.
- Scans the input one CHUNK-bit slice per cycle, MSB slice first, using one shared combinational clz instance of CHUNK bits.
- Returns the leading-zero count, an all-zero flag and the left-normalised word.
- Sits ahead of the normalisation and shift stages; it trades latency for a short critical path.

---
 rtl/clz_seq_pkg.sv | 21 ++
 rtl/clz_seq_if.sv | 30 +++
 rtl/clz_seq_clz.sv | 22 ++
 rtl/clz_seq.sv | 114 +++++++++++
 tb/tb_clz_seq.sv | 141 ++++++++++++++
 5 files changed

// File: rtl/clz_seq_pkg.sv
// Shared types and helpers for the multi-cycle leading-zero counter.
package clz_seq_pkg;

  // Controller states; encodings are fixed so they can be probed from outside.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  // Ceiling log2, usable in parameter and port-width expressions.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < value) r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/clz_seq_if.sv
// Input/output handshake bundle of clz_seq. Bit 0 of the data words is the MSB.
interface clz_seq_if import clz_seq_pkg::*; #(
  parameter int WIDTH = 32
) ();

  localparam int CNT_W = clog2(WIDTH) + 1;

  logic             in_valid;
  logic             in_ready;
  logic [0:WIDTH-1] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [CNT_W-1:0] out_count;
  logic             out_zero;
  logic [0:WIDTH-1] out_norm;
  logic             busy;

  // Producer/consumer side driving words in and taking results out.
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_count, out_zero, out_norm, busy
  );

  // The counter itself.
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_count, out_zero, out_norm, busy
  );

endinterface

// File: rtl/clz_seq_clz.sv
// Combinational leading-zero detector for one slice. Bit 0 is the MSB;
// pout is the index of the first set bit and is only meaningful when vout=1.
module clz_seq_clz import clz_seq_pkg::*; #(
  parameter int BITS_IN = 8
) (
  input  logic [0:BITS_IN-1]          din,
  output logic                        vout,
  output logic [clog2(BITS_IN)-1:0]   pout
);

  localparam int POS_W = clog2(BITS_IN);

  // Priority encode from the LSB side upward so the lowest index (MSB) wins.
  always_comb begin
    vout = |din;
    pout = '0;
    for (int i = BITS_IN - 1; i >= 0; i--) begin
      if (din[i]) pout = POS_W'(i);
    end
  end

endmodule

// File: rtl/clz_seq.sv
// Multi-cycle leading-zero counter and normaliser: scans one CHUNK-bit slice
// per cycle, MSB slice first, through a single shared slice-wide detector.
//
//   state | meaning
//   IDLE  | waiting for an input word, in_ready=1
//   SCAN  | examining slice idx at the top of the shift register
//   DONE  | result registered, out_valid=1 until out_ready
module clz_seq import clz_seq_pkg::*; #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic      clk,
  input  logic      rst,
  clz_seq_if.slave  bus
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CNT_W  = clog2(WIDTH) + 1;
  localparam int IDX_W  = (NCHUNK > 1) ? clog2(NCHUNK) : 1;
  localparam int POS_W  = clog2(CHUNK);

  state_t             state;
  state_t             state_nxt;
  logic [0:WIDTH-1]   sr;
  logic [IDX_W-1:0]   idx;
  logic [CNT_W-1:0]   count_q;
  logic               zero_q;
  logic [0:WIDTH-1]   norm_q;
  logic               hit;
  logic [POS_W-1:0]   pos;
  logic               last;
  logic               in_ready;
  logic               out_valid;
  logic               busy;

  assign last = (idx == IDX_W'(NCHUNK - 1));

  clz_seq_clz #(
    .BITS_IN (CHUNK)
  ) u_clz (
    .din  (sr[0:CHUNK-1]),
    .vout (hit),
    .pout (pos)
  );

  // State register; reset drops any word in flight.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state decision from the handshakes and the slice detector.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.in_valid)   state_nxt = SCAN;
      SCAN:    if (hit || last)    state_nxt = DONE;
      DONE:    if (bus.out_ready)  state_nxt = IDLE;
      default:                     state_nxt = IDLE;
    endcase
  end

  // Handshake outputs depend on the registered state only.
  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    busy      = (state != IDLE);
  end

  // Datapath: capture, slice-by-slice shift, and result registers. Since the
  // register has already moved up by idx*CHUNK, the normalising shift only
  // needs to span 0..CHUNK-1, and idx*CHUNK+pos is just {idx, pos}.
  always_ff @(posedge clk) begin
    if (rst) begin
      sr      <= '0;
      idx     <= '0;
      count_q <= '0;
      zero_q  <= 1'b0;
      norm_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            sr  <= bus.in_data;
            idx <= '0;
          end
        end
        SCAN: begin
          if (hit) begin
            count_q <= CNT_W'({idx, pos});
            norm_q  <= sr << pos;
            zero_q  <= 1'b0;
          end else if (last) begin
            count_q <= CNT_W'(WIDTH);
            norm_q  <= '0;
            zero_q  <= 1'b1;
          end else begin
            sr  <= sr << CHUNK;
            idx <= idx + IDX_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.busy      = busy;
  assign bus.out_count = count_q;
  assign bus.out_zero  = zero_q;
  assign bus.out_norm  = norm_q;

endmodule

// File: tb/tb_clz_seq.sv
// Self-checking bench for clz_seq: directed cases plus random words compared
// against a bit-scan reference model.
module tb_clz_seq;
  import clz_seq_pkg::*;

  localparam int WIDTH  = 32;
  localparam int CHUNK  = 8;
  localparam int NCHUNK = WIDTH / CHUNK;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  clz_seq_if #(.WIDTH(WIDTH)) bus ();

  clz_seq #(
    .WIDTH (WIDTH),
    .CHUNK (CHUNK)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: number of zeros before the first set bit, scanning from the MSB.
  function automatic int ref_lz(input logic [31:0] d);
    for (int i = 0; i < WIDTH; i++) begin
      if (d[WIDTH-1-i]) return i;
    end
    return WIDTH;
  endfunction

  // Send one word, check latency and result, optionally stall the consumer
  // (offering another word meanwhile), then check the return to idle.
  task automatic run_word(input logic [31:0] d, input int stall,
                          input bit offer_next, input logic [31:0] nxt);
    int lz, k, waited, edges;
    logic [31:0] exp_norm;
    lz       = ref_lz(d);
    k        = (lz == WIDTH) ? NCHUNK - 1 : lz / CHUNK;
    exp_norm = (lz == WIDTH) ? 32'h0 : d << lz;
    waited = 0;
    while (!bus.in_ready && waited < 50) begin
      @(posedge clk); #1;
      waited++;
    end
    check("idle_gap", waited, 0);
    bus.in_valid  = 1'b1;
    bus.in_data   = d;
    bus.out_ready = (stall == 0);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check("rdy_busy", {bus.in_ready, bus.busy}, 2'b01);
    edges = 0;
    while (!bus.out_valid && edges < 20) begin
      @(posedge clk); #1;
      edges++;
    end
    check("latency", edges, k + 1);
    check("count", bus.out_count, lz);
    check("zero", bus.out_zero, (lz == WIDTH));
    check("norm", bus.out_norm, exp_norm);
    for (int s = 0; s < stall; s++) begin
      if (offer_next) begin
        bus.in_valid = 1'b1;
        bus.in_data  = nxt;
      end
      @(posedge clk); #1;
      check("hold_ctl", {bus.out_valid, bus.in_ready, bus.busy}, 3'b101);
      check("hold_data", {bus.out_count, bus.out_zero, bus.out_norm},
            {6'(lz), (lz == WIDTH), exp_norm});
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    check("post_idle", {bus.out_valid, bus.in_ready, bus.busy}, 3'b010);
    check("post_hold", {bus.out_count, bus.out_norm}, {6'(lz), exp_norm});
  endtask

  initial begin
    logic [31:0] d;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_ctl", {bus.out_valid, bus.in_ready, bus.busy}, 3'b010);
    check("rst_data", {bus.out_count, bus.out_zero, bus.out_norm}, 39'h0);

    run_word(32'h8000_0000, 0, 1'b0, 32'h0);
    run_word(32'h0000_1234, 0, 1'b0, 32'h0);
    run_word(32'h0000_0000, 0, 1'b0, 32'h0);
    run_word(32'h00FF_0000, 6, 1'b1, 32'hFFFF_FFFF);
    run_word(32'hFFFF_FFFF, 0, 1'b0, 32'h0);
    run_word(32'h0000_1234, 0, 1'b0, 32'h0);

    // Reset during the second scan cycle of a word.
    bus.in_valid = 1'b1;
    bus.in_data  = 32'h0000_0001;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mid_rst_ctl", {bus.out_valid, bus.in_ready, bus.busy}, 3'b010);
    check("mid_rst_data", {bus.out_count, bus.out_zero, bus.out_norm}, 39'h0);
    repeat (5) @(posedge clk);
    #1 check("mid_rst_quiet", {bus.out_valid, bus.busy}, 2'b00);
    run_word(32'h0000_0001, 0, 1'b0, 32'h0);

    run_word(32'h0100_0000, 0, 1'b0, 32'h0);
    run_word(32'h0000_0080, 0, 1'b0, 32'h0);

    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 3))
        0:       d = 32'h0;
        1:       d = $urandom;
        2:       d = $urandom >> $urandom_range(0, 31);
        default: d = 32'h1 << $urandom_range(0, 31);
      endcase
      run_word(d, int'($urandom_range(0, 2)), 1'b0, 32'h0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
